// File: rtl/scroll_pkg.sv
// scroll_pkg: shared state encoding, rate table and period helpers for scroll_scheduler
package scroll_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;
  localparam int RATES [4] = '{1, 2, 4, 8};
  function automatic int period(input int f, input int idx);
    return f / RATES[idx];
  endfunction
  function automatic int cnt_width(input int f);
    return $clog2(f);
  endfunction
endpackage

// File: rtl/scroll_scheduler_tick_gen.sv
// tick_gen: clearable period counter emitting a one-cycle tick at the terminal count
module tick_gen #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic         tick
);
  logic [W-1:0] cnt;
  assign tick = en && !clr && cnt == term;
  always_ff @(posedge clk)
    cnt <= (rst || clr || !en || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/scroll_scheduler.sv
// scroll_scheduler: run/pause/step sequencer stepping a message index at a selectable strobe rate
module scroll_scheduler
  import scroll_pkg::*;
#(
  parameter int F_INPUT = 50000000,
  parameter int MSG_LEN = 16
) (
  input  logic                       clk_in,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       step,
  input  logic                       dir,
  input  logic [1:0]                 rate_sel,
  output logic [$clog2(MSG_LEN)-1:0] pos,
  output logic                       advance,
  output logic                       wrap,
  output logic                       running
);
  localparam int CW = cnt_width(F_INPUT);
  localparam int PW = $clog2(MSG_LEN);
  localparam logic [PW-1:0] LAST = PW'(MSG_LEN - 1);
  localparam logic [CW-1:0] T0 = CW'(period(F_INPUT, 0) - 1);
  localparam logic [CW-1:0] T1 = CW'(period(F_INPUT, 1) - 1);
  localparam logic [CW-1:0] T2 = CW'(period(F_INPUT, 2) - 1);
  localparam logic [CW-1:0] T3 = CW'(period(F_INPUT, 3) - 1);
  state_t state, nxt;
  logic [1:0] rate_q;
  logic [CW-1:0] term;
  logic [PW-1:0] pos_nxt;
  logic step_q, step_ok, tick, adv, wr;
  tick_gen #(.W(CW)) u_tick (
    .clk(clk_in),
    .rst(reset),
    .clr(stop || rate_sel != rate_q),
    .en(state == RUN),
    .term(term),
    .tick(tick)
  );
  // step is latched first so its advance lands one cycle after acceptance
  always_comb begin
    nxt = state;
    if (stop) nxt = (state == RUN) ? PAUSED : state;
    else if (start) nxt = RUN;
    step_ok = step && !stop && !start && state != RUN;
    term = rate_q[1] ? (rate_q[0] ? T3 : T2) : (rate_q[0] ? T1 : T0);
    adv = step_q || tick;
    wr = adv && (dir ? pos == '0 : pos == LAST);
    pos_nxt = dir ? (pos == '0 ? LAST : pos - 1'b1) : (pos == LAST ? '0 : pos + 1'b1);
  end
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state <= IDLE;
      rate_q <= '0;
      step_q <= 1'b0;
      advance <= 1'b0;
      wrap <= 1'b0;
      pos <= '0;
    end else begin
      state <= nxt;
      rate_q <= rate_sel;
      step_q <= step_ok;
      advance <= adv;
      wrap <= wr;
      if (adv) pos <= pos_nxt;
    end
  end
  assign running = state == RUN;
endmodule

// File: tb/tb_scroll_scheduler.sv
// tb_scroll_scheduler: directed checks of run/pause/step, rate change and reset behaviour
module tb_scroll_scheduler;
  logic clk_in = 1'b0, reset = 1'b1, start = 1'b0, stop = 1'b0, step = 1'b0, dir = 1'b0;
  logic [1:0] rate_sel = 2'd0;
  logic [3:0] pos;
  logic advance, wrap, running;
  int tests = 0, fails = 0;
  scroll_scheduler #(.F_INPUT(80), .MSG_LEN(16)) dut (
    .clk_in(clk_in), .reset(reset), .start(start), .stop(stop), .step(step),
    .dir(dir), .rate_sel(rate_sel), .pos(pos), .advance(advance), .wrap(wrap),
    .running(running)
  );
  always #5 clk_in = ~clk_in;
  task automatic pulse(input logic a, input logic o, input logic p);
    start = a; stop = o; step = p;
    @(negedge clk_in);
    start = 1'b0; stop = 1'b0; step = 1'b0;
  endtask
  task automatic wait_adv(input int lim, output int got);
    got = -1;
    for (int i = 1; i <= lim; i++) begin
      @(negedge clk_in);
      if (advance === 1'b1) begin
        got = i;
        break;
      end
    end
  endtask
  task automatic test_reset;
    logic seen_adv, seen_run;
    seen_adv = 1'b0; seen_run = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk_in);
    reset = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_in);
      seen_adv |= advance;
      seen_run |= running;
    end
    tests++; if (pos !== 4'd0) begin fails++; $display("FAIL reset_pos got %0d want 0", pos); end
    tests++; if (seen_adv !== 1'b0) begin fails++; $display("FAIL reset_adv got %b want 0", seen_adv); end
    tests++; if (seen_run !== 1'b0) begin fails++; $display("FAIL reset_run got %b want 0", seen_run); end
  endtask
  task automatic test_run_rate3;
    int got;
    rate_sel = 2'd3; dir = 1'b0;
    pulse(1, 0, 0);
    tests++; if (running !== 1'b1) begin fails++; $display("FAIL run3_running got %b want 1", running); end
    for (int i = 1; i <= 16; i++) begin
      wait_adv(15, got);
      tests++; if (got !== 10) begin fails++; $display("FAIL run3_period[%0d] got %0d want 10", i, got); end
      tests++; if (pos !== 4'(i % 16)) begin fails++; $display("FAIL run3_pos[%0d] got %0d want %0d", i, pos, i % 16); end
      tests++; if (wrap !== (i == 16)) begin fails++; $display("FAIL run3_wrap[%0d] got %b want %b", i, wrap, i == 16); end
    end
    pulse(0, 1, 0);
    tests++; if (running !== 1'b0) begin fails++; $display("FAIL run3_pause got %b want 0", running); end
  endtask
  task automatic test_rate_change;
    int got;
    rate_sel = 2'd0;
    pulse(1, 0, 0);
    wait_adv(49, got);
    tests++; if (got !== -1) begin fails++; $display("FAIL rchg_early got %0d want -1", got); end
    rate_sel = 2'd2;
    wait_adv(30, got);
    tests++; if (got !== 21 || pos !== 4'd1) begin fails++; $display("FAIL rchg_first got %0d/pos %0d want 21/pos 1", got, pos); end
    wait_adv(30, got);
    tests++; if (got !== 20 || pos !== 4'd2) begin fails++; $display("FAIL rchg_next got %0d/pos %0d want 20/pos 2", got, pos); end
  endtask
  task automatic test_stop_start;
    int got;
    wait_adv(19, got);
    tests++; if (got !== -1) begin fails++; $display("FAIL ss_pre got %0d want -1", got); end
    pulse(1, 1, 0);
    tests++; if (advance !== 1'b0) begin fails++; $display("FAIL ss_term_adv got %b want 0", advance); end
    tests++; if (running !== 1'b0) begin fails++; $display("FAIL ss_running got %b want 0", running); end
    wait_adv(60, got);
    tests++; if (got !== -1 || pos !== 4'd2) begin fails++; $display("FAIL ss_hold got %0d/pos %0d want -1/pos 2", got, pos); end
    pulse(1, 0, 0);
    wait_adv(25, got);
    tests++; if (got !== 20 || pos !== 4'd3) begin fails++; $display("FAIL ss_resume got %0d/pos %0d want 20/pos 3", got, pos); end
    pulse(0, 0, 1);
    @(negedge clk_in);
    tests++; if (advance !== 1'b0 || pos !== 4'd3) begin fails++; $display("FAIL ss_step_run adv %b/pos %0d want 0/pos 3", advance, pos); end
    pulse(0, 1, 0);
  endtask
  task automatic test_step;
    dir = 1'b1;
    step = 1'b1;
    @(negedge clk_in);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk_in);
      if (i == 2) step = 1'b0;
      tests++; if (advance !== 1'b1 || pos !== 4'(3 - i) || wrap !== 1'b0) begin fails++; $display("FAIL step_b2b[%0d] adv %b/pos %0d/wrap %b want 1/%0d/0", i, advance, pos, wrap, 3 - i); end
    end
    @(negedge clk_in);
    tests++; if (advance !== 1'b0) begin fails++; $display("FAIL step_b2b_end got %b want 0", advance); end
    pulse(0, 0, 1);
    tests++; if (advance !== 1'b0) begin fails++; $display("FAIL step_lat got %b want 0", advance); end
    @(negedge clk_in);
    tests++; if (advance !== 1'b1 || pos !== 4'd15 || wrap !== 1'b1) begin fails++; $display("FAIL step_bwrap adv %b/pos %0d/wrap %b want 1/15/1", advance, pos, wrap); end
    dir = 1'b0;
    pulse(0, 0, 1);
    @(negedge clk_in);
    tests++; if (advance !== 1'b1 || pos !== 4'd0 || wrap !== 1'b1) begin fails++; $display("FAIL step_fwrap adv %b/pos %0d/wrap %b want 1/0/1", advance, pos, wrap); end
    tests++; if (running !== 1'b0) begin fails++; $display("FAIL step_state got %b want 0", running); end
  endtask
  task automatic test_reset_mid;
    int got;
    rate_sel = 2'd3;
    pulse(1, 0, 0);
    for (int i = 0; i < 5; i++) wait_adv(15, got);
    tests++; if (pos !== 4'd5) begin fails++; $display("FAIL rmid_pre got %0d want 5", pos); end
    repeat (4) @(negedge clk_in);
    reset = 1'b1;
    @(negedge clk_in);
    reset = 1'b0;
    tests++; if (pos !== 4'd0 || running !== 1'b0 || advance !== 1'b0) begin fails++; $display("FAIL rmid_state pos %0d/run %b/adv %b want 0/0/0", pos, running, advance); end
    wait_adv(100, got);
    tests++; if (got !== -1) begin fails++; $display("FAIL rmid_quiet got %0d want -1", got); end
  endtask
  initial begin
    repeat (2) @(negedge clk_in);
    test_reset;
    test_run_rate3;
    test_rate_change;
    test_stop_start;
    test_step;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
